bist_rsp_cmp: RTL and testbench
===============================

// Module: bist_rsp_cmp
// PURPOSE
//  BIST response analyzer; receive side of the registered BIST memory command path (cs/we/pat).
//  Tracks issued reads through a latency-matched delay line and compares memory read data
//  against the expected pattern. Accumulates pass/fail, a saturating error count and a
//  first-fail record. Sits between the memory macro read port and the BIST controller.
// PARAMETERS
//  pDATA_WIDTH  2   width of pattern / read data
//  pADDR_WIDTH  8   width of memory address
//  pRD_LAT      1   cycles from registered read command to valid mem_rdata (>=1)
//  pCNT_WIDTH   8   error counter width
// PORTS
//  bist_clk       in   1            BIST clock
//  bist_rst_n     in   1            async active-low reset
//  bist_start     in   1            pulse: clear results, begin a test run
//  bist_end       in   1            pulse: last command of the run is on buf_* this cycle
//  buf_cs         in   1            registered chip select to memory
//  buf_we         in   1            registered write enable (0 = read)
//  buf_pat        in   pDATA_WIDTH  expected data for reads
//  buf_addr       in   pADDR_WIDTH  registered memory address
//  mem_rdata      in   pDATA_WIDTH  memory read data
//  cmp_busy       out  1            high in RUN or DRAIN
//  cmp_done       out  1            high in DONE; results stable
//  cmp_fail       out  1            sticky: >=1 mismatch this run
//  cmp_err_cnt    out  pCNT_WIDTH   mismatch count, saturating
//  cmp_fail_addr  out  pADDR_WIDTH  address of first mismatch
//  cmp_fail_exp   out  pDATA_WIDTH  expected data of first mismatch
//  cmp_fail_act   out  pDATA_WIDTH  actual data of first mismatch
// BEHAVIOUR
//  - Reset (bist_rst_n, asynchronous, active-low; clock bist_clk): state IDLE, delay line
//    flushed, all outputs 0.
//  - FSM IDLE -> RUN on bist_start; RUN -> DRAIN on bist_end; DRAIN -> DONE after pRD_LAT
//    cycles; DONE holds until bist_start.
//  - bist_start in any state: results cleared, delay line flushed, next state RUN. bist_start
//    and bist_end in the same cycle: start wins, end ignored.
//  - Read issue: buf_cs=1 & buf_we=0 & state==RUN (including the bist_end cycle). Push
//    {valid, buf_pat, buf_addr} into a pRD_LAT-deep delay line; writes and idle push valid=0.
//  - Compare: at delay-line output, valid=1 -> compare mem_rdata with the delayed pattern in
//    the same cycle. Compares are live in RUN and DRAIN only.
//  - On mismatch: cmp_fail<=1 next edge; cmp_err_cnt+1 unless all-ones (saturate, no wrap).
//    If cmp_fail was 0, capture addr/exp/act; later mismatches never overwrite.
//  - Back-to-back reads: one compare per cycle, no bubbles required.
//  - Outputs registered; cmp_done rises the cycle after the last in-flight read is compared.
// STRUCTURE
//  - Shared package: FSM state encodings (IDLE/RUN/DRAIN/DONE) and default parameter values.
//  - One sub-module: bist_rsp_dly, a parameterised pRD_LAT-stage shift register with async
//    reset and sync flush, carrying {valid, pat, addr}.
// TESTING
//  1. pRD_LAT=1: start, 4 reads with pat=2'b10, mem_rdata=2'b10, end -> done, fail=0, cnt=0.
//  2. Read addr 8'h05 exp 2'b01, mem returns 2'b11 -> fail=1, cnt=1, addr=05, exp=01, act=11.
//  3. Mismatches at addr 03 then 07 -> cnt=2, first-fail record stays at addr 03.
//  4. pCNT_WIDTH=2: 5 mismatching reads -> cmp_err_cnt=2'b11, no wrap.
//  5. pRD_LAT=3: end on the cycle of the last read -> busy 3 cycles, last read compared,
//     done on the 4th edge.
//  6. Writes only (we=1), mismatching rdata -> fail=0. Then bist_start mid-DRAIN -> results
//     clear, in-flight reads dropped.

Source files
------------

// File: rtl/bist_rsp_cmp_pkg.sv
// Shared types and default parameters for the BIST response analyzer.
// Imported by the top and by the read-tracking delay line.
package bist_rsp_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cmp_state_e;

  localparam int DEF_DATA_WIDTH = 2;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/bist_rsp_dly.sv
// Latency-matched shift register carrying {valid, pat, addr} for each issued read.
// Its last stage lines up with the cycle the memory returns data for that read.
module bist_rsp_dly
  import bist_rsp_cmp_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int pRD_LAT     = DEF_RD_LAT
) (
  input  logic                   bist_clk,
  input  logic                   bist_rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [pDATA_WIDTH-1:0] in_pat,
  input  logic [pADDR_WIDTH-1:0] in_addr,
  output logic                   out_valid,
  output logic [pDATA_WIDTH-1:0] out_pat,
  output logic [pADDR_WIDTH-1:0] out_addr
);

  localparam int W = 1 + pDATA_WIDTH + pADDR_WIDTH;

  logic [W-1:0] stage_q [pRD_LAT];

  // A flush empties every stage so reads from an abandoned run are never compared.
  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      for (int i = 0; i < pRD_LAT; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < pRD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= {in_valid, in_pat, in_addr};
      for (int i = 1; i < pRD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign {out_valid, out_pat, out_addr} = stage_q[pRD_LAT-1];

endmodule

// File: rtl/bist_rsp_cmp.sv
// BIST response analyzer: compares returning memory read data against the expected
// pattern and keeps pass/fail, a saturating error count and a first-fail record.
module bist_rsp_cmp
  import bist_rsp_cmp_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int pADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int pRD_LAT     = DEF_RD_LAT,
  parameter int pCNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                   bist_clk,
  input  logic                   bist_rst_n,
  input  logic                   bist_start,
  input  logic                   bist_end,
  input  logic                   buf_cs,
  input  logic                   buf_we,
  input  logic [pDATA_WIDTH-1:0] buf_pat,
  input  logic [pADDR_WIDTH-1:0] buf_addr,
  input  logic [pDATA_WIDTH-1:0] mem_rdata,
  output logic                   cmp_busy,
  output logic                   cmp_done,
  output logic                   cmp_fail,
  output logic [pCNT_WIDTH-1:0]  cmp_err_cnt,
  output logic [pADDR_WIDTH-1:0] cmp_fail_addr,
  output logic [pDATA_WIDTH-1:0] cmp_fail_exp,
  output logic [pDATA_WIDTH-1:0] cmp_fail_act
);

  localparam int CW = $clog2(pRD_LAT) + 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(pRD_LAT - 1);

  cmp_state_e state_q, state_d;
  logic [CW-1:0] drain_cnt_q;

  logic                   rd_issue;
  logic                   dly_valid;
  logic [pDATA_WIDTH-1:0] dly_pat;
  logic [pADDR_WIDTH-1:0] dly_addr;
  logic                   cmp_live;
  logic                   mismatch;

  assign rd_issue = buf_cs & ~buf_we & (state_q == ST_RUN);

  bist_rsp_dly #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pADDR_WIDTH (pADDR_WIDTH),
    .pRD_LAT     (pRD_LAT)
  ) u_dly (
    .bist_clk   (bist_clk),
    .bist_rst_n (bist_rst_n),
    .flush      (bist_start),
    .in_valid   (rd_issue),
    .in_pat     (buf_pat),
    .in_addr    (buf_addr),
    .out_valid  (dly_valid),
    .out_pat    (dly_pat),
    .out_addr   (dly_addr)
  );

  assign cmp_live = dly_valid & ((state_q == ST_RUN) | (state_q == ST_DRAIN));
  assign mismatch = cmp_live & (mem_rdata != dly_pat);

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // A start always restarts the run, even when it coincides with bist_end.
  always_comb begin
    state_d = state_q;
    if (bist_start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (bist_end) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n)                                      drain_cnt_q <= '0;
    else if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) drain_cnt_q <= drain_cnt_q + 1'b1;
    else                                                  drain_cnt_q <= '0;
  end

  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      cmp_busy <= 1'b0;
      cmp_done <= 1'b0;
    end else begin
      cmp_busy <= (state_d == ST_RUN) | (state_d == ST_DRAIN);
      cmp_done <= (state_d == ST_DONE);
    end
  end

  // Only the first mismatch of a run is recorded; the counter sticks at all-ones.
  always_ff @(posedge bist_clk or negedge bist_rst_n) begin
    if (!bist_rst_n) begin
      cmp_fail      <= 1'b0;
      cmp_err_cnt   <= '0;
      cmp_fail_addr <= '0;
      cmp_fail_exp  <= '0;
      cmp_fail_act  <= '0;
    end else if (bist_start) begin
      cmp_fail      <= 1'b0;
      cmp_err_cnt   <= '0;
      cmp_fail_addr <= '0;
      cmp_fail_exp  <= '0;
      cmp_fail_act  <= '0;
    end else if (mismatch) begin
      cmp_fail <= 1'b1;
      if (~&cmp_err_cnt) cmp_err_cnt <= cmp_err_cnt + 1'b1;
      if (!cmp_fail) begin
        cmp_fail_addr <= dly_addr;
        cmp_fail_exp  <= dly_pat;
        cmp_fail_act  <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bist_rsp_cmp.sv
// Directed bench for bist_rsp_cmp: three instances (default, 2-bit counter, 3-cycle latency)
// share one command stream; a small memory model returns read data at each latency.
module tb_bist_rsp_cmp;

  logic bist_clk = 1'b0;
  always #5 bist_clk = ~bist_clk;

  logic       bist_rst_n;
  logic       bist_start;
  logic       bist_end;
  logic       buf_cs;
  logic       buf_we;
  logic [1:0] buf_pat;
  logic [7:0] buf_addr;

  logic [1:0] tb_mem [256];
  logic [1:0] rd_l1, rd_l3_0, rd_l3_1, rd_l3_2;

  // Memory model: data for the registered address appears 1 or 3 cycles later.
  always @(posedge bist_clk) begin
    rd_l1   <= tb_mem[buf_addr];
    rd_l3_0 <= tb_mem[buf_addr];
    rd_l3_1 <= rd_l3_0;
    rd_l3_2 <= rd_l3_1;
  end

  logic       a_busy, a_done, a_fail;
  logic [7:0] a_cnt;
  logic [7:0] a_addr;
  logic [1:0] a_exp, a_act;

  logic       s_busy, s_done, s_fail;
  logic [1:0] s_cnt;
  logic [7:0] s_addr;
  logic [1:0] s_exp, s_act;

  logic       l_busy, l_done, l_fail;
  logic [7:0] l_cnt;
  logic [7:0] l_addr;
  logic [1:0] l_exp, l_act;

  bist_rsp_cmp u_dut (
    .bist_clk(bist_clk), .bist_rst_n(bist_rst_n), .bist_start(bist_start), .bist_end(bist_end),
    .buf_cs(buf_cs), .buf_we(buf_we), .buf_pat(buf_pat), .buf_addr(buf_addr), .mem_rdata(rd_l1),
    .cmp_busy(a_busy), .cmp_done(a_done), .cmp_fail(a_fail), .cmp_err_cnt(a_cnt),
    .cmp_fail_addr(a_addr), .cmp_fail_exp(a_exp), .cmp_fail_act(a_act)
  );

  bist_rsp_cmp #(.pCNT_WIDTH(2)) u_sat (
    .bist_clk(bist_clk), .bist_rst_n(bist_rst_n), .bist_start(bist_start), .bist_end(bist_end),
    .buf_cs(buf_cs), .buf_we(buf_we), .buf_pat(buf_pat), .buf_addr(buf_addr), .mem_rdata(rd_l1),
    .cmp_busy(s_busy), .cmp_done(s_done), .cmp_fail(s_fail), .cmp_err_cnt(s_cnt),
    .cmp_fail_addr(s_addr), .cmp_fail_exp(s_exp), .cmp_fail_act(s_act)
  );

  bist_rsp_cmp #(.pRD_LAT(3)) u_lat3 (
    .bist_clk(bist_clk), .bist_rst_n(bist_rst_n), .bist_start(bist_start), .bist_end(bist_end),
    .buf_cs(buf_cs), .buf_we(buf_we), .buf_pat(buf_pat), .buf_addr(buf_addr), .mem_rdata(rd_l3_2),
    .cmp_busy(l_busy), .cmp_done(l_done), .cmp_fail(l_fail), .cmp_err_cnt(l_cnt),
    .cmp_fail_addr(l_addr), .cmp_fail_exp(l_exp), .cmp_fail_act(l_act)
  );

  int check_cnt = 0;
  int error_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of command inputs, then settle just after the clock edge.
  task automatic applyStimulus(input logic start, input logic en, input logic cs,
                               input logic we, input logic [7:0] addr, input logic [1:0] pat);
    bist_start = start;
    bist_end   = en;
    buf_cs     = cs;
    buf_we     = we;
    buf_addr   = addr;
    buf_pat    = pat;
    @(posedge bist_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 2'b00;
    bist_rst_n = 1'b0;
    bist_start = 1'b0;
    bist_end   = 1'b0;
    buf_cs     = 1'b0;
    buf_we     = 1'b0;
    buf_addr   = 8'h00;
    buf_pat    = 2'b00;
    repeat (3) @(posedge bist_clk);
    #1;
    checkOutput("rst_busy", a_busy, 0);
    checkOutput("rst_done", a_done, 0);
    checkOutput("rst_fail", a_fail, 0);
    checkOutput("rst_cnt",  a_cnt,  0);
    checkOutput("rst_addr", a_addr, 0);
    checkOutput("rst_l3_done", l_done, 0);
    bist_rst_n = 1'b1;
    idle(1);
    checkOutput("idle_busy", a_busy, 0);

    // Test 1: four matching reads, plus drain timing for both latencies
    for (int i = 0; i < 4; i++) tb_mem[i] = 2'b10;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    checkOutput("t1_start_busy", a_busy, 1);
    checkOutput("t1_start_done", a_done, 0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, (i == 3), 1'b1, 1'b0, 8'(i), 2'b10);
    checkOutput("t1_drain_busy", a_busy, 1);
    checkOutput("t1_l3_drain1_busy", l_busy, 1);
    idle(1);
    checkOutput("t1_done", a_done, 1);
    checkOutput("t1_done_busy", a_busy, 0);
    checkOutput("t1_l3_drain2_busy", l_busy, 1);
    idle(1);
    checkOutput("t1_l3_drain3_busy", l_busy, 1);
    checkOutput("t1_l3_drain3_done", l_done, 0);
    idle(1);
    checkOutput("t1_l3_done", l_done, 1);
    checkOutput("t1_l3_done_busy", l_busy, 0);
    checkOutput("t1_fail", a_fail, 0);
    checkOutput("t1_cnt", a_cnt, 0);
    checkOutput("t1_l3_fail", l_fail, 0);

    // Test 2: single mismatch at 05, end on the read itself
    tb_mem[5] = 2'b11;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 2'b01);
    idle(3);
    checkOutput("t2_done", a_done, 1);
    checkOutput("t2_fail", a_fail, 1);
    checkOutput("t2_cnt", a_cnt, 1);
    checkOutput("t2_addr", a_addr, 8'h05);
    checkOutput("t2_exp", a_exp, 2'b01);
    checkOutput("t2_act", a_act, 2'b11);
    checkOutput("t2_l3_fail", l_fail, 1);
    checkOutput("t2_l3_cnt", l_cnt, 1);
    checkOutput("t2_l3_addr", l_addr, 8'h05);
    checkOutput("t2_l3_act", l_act, 2'b11);

    // Test 3: mismatches at 03 and 07 with a matching read between
    tb_mem[3] = 2'b00;
    tb_mem[4] = 2'b10;
    tb_mem[7] = 2'b00;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 2'b01);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 2'b11);
    idle(3);
    checkOutput("t3_cnt", a_cnt, 2);
    checkOutput("t3_addr", a_addr, 8'h03);
    checkOutput("t3_exp", a_exp, 2'b01);
    checkOutput("t3_act", a_act, 2'b00);
    checkOutput("t3_l3_cnt", l_cnt, 2);
    checkOutput("t3_l3_addr", l_addr, 8'h03);

    // Test 4: five back-to-back mismatches saturate the 2-bit counter
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, (i == 4), 1'b1, 1'b0, 8'h05, 2'b00);
    idle(3);
    checkOutput("t4_sat_cnt", s_cnt, 2'b11);
    checkOutput("t4_sat_fail", s_fail, 1);
    checkOutput("t4_sat_addr", s_addr, 8'h05);
    checkOutput("t4_cnt", a_cnt, 5);
    checkOutput("t4_l3_cnt", l_cnt, 5);

    // Test 6: writes never compare; restart mid-drain drops the in-flight read
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, (i == 3), 1'b1, 1'b1, 8'h05, 2'b00);
    idle(3);
    checkOutput("t6_wr_done", a_done, 1);
    checkOutput("t6_wr_fail", a_fail, 0);
    checkOutput("t6_wr_cnt", a_cnt, 0);
    checkOutput("t6_wr_l3_fail", l_fail, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 2'b00);
    checkOutput("t6_drain_busy", a_busy, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    checkOutput("t6_restart_fail", a_fail, 0);
    checkOutput("t6_restart_cnt", a_cnt, 0);
    checkOutput("t6_restart_busy", a_busy, 1);
    checkOutput("t6_restart_done", a_done, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00);
    idle(3);
    checkOutput("t6_end_done", a_done, 1);
    checkOutput("t6_end_fail", a_fail, 0);
    checkOutput("t6_end_l3_done", l_done, 1);
    checkOutput("t6_end_l3_fail", l_fail, 0);
    checkOutput("t6_end_l3_cnt", l_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
